// File: rtl/nor_chain_pulse_tester.sv
// Pulse-train stimulus into a CHANNELS-wide, STAGES-deep NOR2 chain.
// Chain outputs are synchronised and their edges counted per channel, with a verdict at the end of each run.

module NOR2_X2 (
  input  logic A1,
  input  logic A2,
  output logic ZN
);
  assign ZN = ~(A1 | A2);
endmodule

module nor_chain_pulse_tester #(
  parameter int STAGES   = 54,
  parameter int CHANNELS = 2,
  parameter int PW_W     = 8,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      START,
  input  logic [PW_W-1:0]           PULSE_W,
  input  logic [3:0]                PULSE_CNT,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      STIM_OUT,
  output logic [CHANNELS-1:0]       OUT_Z,
  output logic [CHANNELS*CNT_W-1:0] EDGE_CNT,
  output logic [CHANNELS-1:0]       PASS,
  output logic [CNT_W-1:0]          FIRST_LAT
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam int EW     = CNT_W + 5;
  localparam logic [PW_W-1:0]   PW_ONE    = PW_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT} state_t;

  state_t state, state_nxt;

  logic [CHANNELS-1:0] chain [STAGES];
  logic [CHANNELS-1:0] sync1, sync2, prev, edge_flag;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  logic [PW_W-1:0]   pw_q, ph_cnt;
  logic [3:0]        pc_q, idx;
  logic              hi;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lat_run, lat_found;
  logic [EW-1:0]     exp_edges;

  logic accept, ph_end, launch_last, cnt_en;
  logic stim_d, busy_d, done_d;

  // Every stage inverts; an even stage count keeps OUT_Z in phase with STIM_OUT.
  genvar s, k;
  generate
    for (s = 0; s < STAGES; s++) begin : g_stage
      for (k = 0; k < CHANNELS; k++) begin : g_cell
        if (s == 0) begin : g_first
          NOR2_X2 u_nor (.A1(STIM_OUT), .A2(STIM_OUT), .ZN(chain[s][k]));
        end else begin : g_rest
          NOR2_X2 u_nor (.A1(chain[s-1][k]), .A2(chain[s-1][(k+1)%CHANNELS]), .ZN(chain[s][k]));
        end
      end
    end
    for (k = 0; k < CHANNELS; k++) begin : g_cnt_out
      assign EDGE_CNT[k*CNT_W +: CNT_W] = cnt[k];
    end
  endgenerate

  assign OUT_Z     = chain[STAGES-1];
  assign edge_flag = sync2 ^ prev;

  assign accept      = (state == S_IDLE) && START;
  assign ph_end      = (ph_cnt == pw_q - PW_ONE);
  assign launch_last = !hi && ph_end && (idx == pc_q - 4'd1);
  assign cnt_en      = (state == S_LAUNCH) || (state == S_WAIT);
  assign exp_edges   = (pw_q == '0) ? '0 : EW'({pc_q, 1'b0});

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = (PULSE_W == '0 || PULSE_CNT == 4'd0) ? S_WAIT : S_LAUNCH;
      S_LAUNCH: if (launch_last) state_nxt = S_WAIT;
      S_WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = S_REPORT;
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stim_d = (state == S_LAUNCH) && hi;
    busy_d = (state_nxt != S_IDLE);
    done_d = (state == S_REPORT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STIM_OUT <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
    end else begin
      STIM_OUT <= stim_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
      sync1    <= OUT_Z;
      sync2    <= sync1;
      prev     <= sync2;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pw_q     <= '0;
      pc_q     <= '0;
      ph_cnt   <= '0;
      hi       <= 1'b0;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        pw_q   <= PULSE_W;
        pc_q   <= PULSE_CNT;
        ph_cnt <= '0;
        hi     <= 1'b1;
        idx    <= '0;
      end else if (state == S_LAUNCH) begin
        if (ph_end) begin
          ph_cnt <= '0;
          hi     <= ~hi;
          if (!hi) idx <= idx + 4'd1;
        end else begin
          ph_cnt <= ph_cnt + PW_ONE;
        end
      end
      wait_cnt <= (state == S_WAIT) ? wait_cnt + WAIT_ONE : '0;
    end
  end

  // Edges flagged while REPORT is current are deliberately dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      PASS <= '0;
    end else if (accept) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      PASS <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cnt_en && edge_flag[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
        if (state == S_REPORT) PASS[i] <= (EW'(cnt[i]) == exp_edges) && !sync2[i];
      end
    end
  end

  // Latency counts from the first stimulus rise; the freezing edge's cycle is included.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FIRST_LAT <= '0;
      lat_run   <= 1'b0;
      lat_found <= 1'b0;
    end else if (accept) begin
      FIRST_LAT <= '0;
      lat_run   <= 1'b0;
      lat_found <= 1'b0;
    end else if (state == S_REPORT) begin
      lat_run <= 1'b0;
      if (!lat_found) FIRST_LAT <= CNT_MAX;
    end else if (!lat_found && !lat_run && stim_d && !STIM_OUT) begin
      lat_run   <= 1'b1;
      FIRST_LAT <= '0;
    end else if (lat_run) begin
      if (FIRST_LAT != CNT_MAX) FIRST_LAT <= FIRST_LAT + CNT_ONE;
      if (cnt_en && edge_flag[0]) begin
        lat_run   <= 1'b0;
        lat_found <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nor_chain_pulse_tester.sv
// Bench for nor_chain_pulse_tester: default, 4-channel/8-stage and 3-bit-counter instances share one stimulus.
// Expected run results are queued at launch and checked when DONE appears.

module tb_nor_chain_pulse_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] pulse_w = '0;
  logic [3:0] pulse_cnt = '0;

  logic busy0, done0, stim0;  logic [1:0] outz0; logic [31:0] edge0; logic [1:0] pass0; logic [15:0] lat0;
  logic busy1, done1, stim1;  logic [3:0] outz1; logic [63:0] edge1; logic [3:0] pass1; logic [15:0] lat1;
  logic busy2, done2, stim2;  logic [1:0] outz2; logic [5:0]  edge2; logic [1:0] pass2; logic [2:0]  lat2;

  always #5 clk = ~clk;

  nor_chain_pulse_tester dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start), .PULSE_W(pulse_w), .PULSE_CNT(pulse_cnt),
    .BUSY(busy0), .DONE(done0), .STIM_OUT(stim0), .OUT_Z(outz0), .EDGE_CNT(edge0),
    .PASS(pass0), .FIRST_LAT(lat0));

  nor_chain_pulse_tester #(.CHANNELS(4), .STAGES(8)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start), .PULSE_W(pulse_w), .PULSE_CNT(pulse_cnt),
    .BUSY(busy1), .DONE(done1), .STIM_OUT(stim1), .OUT_Z(outz1), .EDGE_CNT(edge1),
    .PASS(pass1), .FIRST_LAT(lat1));

  nor_chain_pulse_tester #(.CNT_W(3)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start), .PULSE_W(pulse_w), .PULSE_CNT(pulse_cnt),
    .BUSY(busy2), .DONE(done2), .STIM_OUT(stim2), .OUT_Z(outz2), .EDGE_CNT(edge2),
    .PASS(pass2), .FIRST_LAT(lat2));

  typedef struct {
    int pw, pc;
    int e0, p0, e1, p1, e2, p2;
    int lat, stim, off, acc;
  } vec_t;

  localparam int T = 255;

  vec_t tbl [6];
  vec_t sb [$];
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, stim_hi = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vec_t e;
    if (!rst_n) stim_hi = 0;
    else if (stim0) stim_hi++;
    if (done0 || done1 || done2) begin
      chk("done_align_d1", int'(done1), int'(done0));
      chk("done_align_d2", int'(done2), int'(done0));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk($sformatf("done_cycle_pw%0d_pc%0d", e.pw, e.pc), cyc, e.acc + e.off);
        chk("busy_at_done", int'(busy0), 0);
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("edge_d0_ch%0d_pw%0d", k, e.pw), int'(edge0[k*16 +: 16]), e.e0);
          chk($sformatf("edge_d2_ch%0d_pw%0d", k, e.pw), int'(edge2[k*3 +: 3]), e.e2);
        end
        for (int k = 0; k < 4; k++)
          chk($sformatf("edge_d1_ch%0d_pw%0d", k, e.pw), int'(edge1[k*16 +: 16]), e.e1);
        chk("pass_d0", int'(pass0), e.p0);
        chk("pass_d1", int'(pass1), e.p1);
        chk("pass_d2", int'(pass2), e.p2);
        chk("first_lat_d0", int'(lat0), e.lat);
        chk("first_lat_d1", int'(lat1), e.lat);
        chk("first_lat_d2", int'(lat2), e.lat & 7);
        chk("stim_high_cycles", stim_hi, e.stim);
        stim_hi = 0;
        done_cnt++;
      end
    end
  end

  task automatic launch(input int pw, input int pc, output int acc);
    @(negedge clk);
    pulse_w   = pw[7:0];
    pulse_cnt = pc[3:0];
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc   = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", done_cnt, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    vec_t v, v1, v2;

    //             pw pc  e0 p0 e1 p1  e2 p2  lat    stim off            acc
    tbl[0] = '{4,  1,  2,  3, 2,  15, 2, 3,  3,     4,   8   + T + 1,   0};
    tbl[1] = '{1,  15, 30, 3, 30, 15, 7, 0,  3,     15,  30  + T + 1,   0};
    tbl[2] = '{0,  5,  0,  3, 0,  15, 0, 3,  65535, 0,   T + 1,         0};
    tbl[3] = '{2,  8,  16, 3, 16, 15, 7, 0,  3,     16,  32  + T + 1,   0};
    tbl[4] = '{3,  0,  0,  3, 0,  15, 0, 3,  65535, 0,   T + 1,         0};
    tbl[5] = '{5,  2,  4,  3, 4,  15, 4, 3,  3,     10,  20  + T + 1,   0};
    n = 0;

    repeat (2) @(negedge clk);
    chk("rst_stim", int'(stim0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_edge_d0", int'(edge0), 0);
    chk("rst_pass_d0", int'(pass0), 0);
    chk("rst_lat_d0", int'(lat0), 0);
    chk("rst_edge_d1_nz", int'(edge1 != 64'd0), 0);
    rst_n = 1'b1;

    // Reset mid-LAUNCH: the first rising edge has been counted by cycle 7.
    launch(5, 3, acc);
    repeat (7) @(negedge clk);
    chk("pre_rst_edge_ch0", int'(edge0[15:0]), 1);
    chk("pre_rst_busy", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stim", int'(stim0), 0);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_edge_d0", int'(edge0), 0);
    chk("midrst_edge_d1_nz", int'(edge1 != 64'd0), 0);
    chk("midrst_edge_d2", int'(edge2), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].pw, tbl[i].pc, acc);
      chk($sformatf("busy_run%0d", i), int'(busy0), 1);
      v = tbl[i];
      v.acc = acc;
      sb.push_back(v);
      n++;
      wait_done(n);
    end

    // Mid-run START ignored (with a PULSE_W change), then START held through REPORT.
    launch(2, 2, acc);
    v1 = '{2, 2, 4, 3, 4, 15, 4, 3, 3, 4, 8 + T + 1, acc};
    v2 = '{7, 1, 2, 3, 2, 15, 2, 3, 3, 7, 14 + T + 1, acc + 8 + T + 1 + 1};
    sb.push_back(v1);
    sb.push_back(v2);
    repeat (3) @(negedge clk);
    start = 1'b1; pulse_w = 8'd7; pulse_cnt = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("midrun_busy", int'(busy0), 1);
    repeat (6) @(negedge clk);
    start = 1'b1;
    wait_done(n + 1);
    @(posedge clk);
    @(negedge clk);
    chk("retrigger_busy", int'(busy0), 1);
    chk("retrigger_cleared_edge", int'(edge0), 0);
    chk("retrigger_cleared_pass", int'(pass0), 0);
    start = 1'b0;
    wait_done(n + 2);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
